// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve unit.
//   entry_t      : one in-flight prediction {pc, ptaken, ptarget}
//   INSTR_BYTES  : fall-through increment applied to a PC
//   DEPTH_DEF    : default in-flight queue depth (power of two, >= 2)
//   CNT_W_DEF    : default statistics counter width
package bp_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int CNT_W_DEF   = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic        ptaken;
    logic [31:0] ptarget;
  } entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between FETCH/EXEC and the branch resolve unit.
//   master : the pipeline side; drives fetch and exec inputs, observes results
//   slave  : the branch resolve unit
// Signals:
//   f_valid/f_pc/f_predict_valid/f_predict_addr : fetch-stage prediction
//   f_stall                                     : in-flight queue full
//   x_valid/x_is_branch/x_taken/x_target        : oldest instruction resolves
//   redirect_valid/redirect_pc                  : mispredict redirect to fetch
//   upd_valid/upd_pc/upd_taken/upd_target       : predictor training
//   stat_branches/stat_mispredicts              : saturating statistics
//   underflow_err                               : sticky exec-without-entry error
interface branch_resolve_unit_if #(
  parameter int CNT_W = bp_pkg::CNT_W_DEF
);
  logic             f_valid;
  logic [31:0]      f_pc;
  logic             f_predict_valid;
  logic [31:0]      f_predict_addr;
  logic             f_stall;

  logic             x_valid;
  logic             x_is_branch;
  logic             x_taken;
  logic [31:0]      x_target;

  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
  logic             underflow_err;

  modport master (
    output f_valid, f_pc, f_predict_valid, f_predict_addr,
    output x_valid, x_is_branch, x_taken, x_target,
    input  f_stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  stat_branches, stat_mispredicts, underflow_err
  );

  modport slave (
    input  f_valid, f_pc, f_predict_valid, f_predict_addr,
    input  x_valid, x_is_branch, x_taken, x_target,
    output f_stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output stat_branches, stat_mispredicts, underflow_err
  );
endinterface

// File: rtl/pred_fifo.sv
// Circular in-order buffer of in-flight predictions.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push       : write wr_data at the tail (caller guarantees !full)
//   pop        : retire the head entry (caller guarantees !empty)
//   flush      : discard every entry; overrides push and pop
//   wr_data    : entry to write
//   head       : oldest entry, combinational
//   full/empty : occupancy flags derived from the count
module pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // NOTE: storage carries no reset; an entry is only read after a push wrote
  // it, and leaving it out of reset keeps it a plain RAM-style array.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the AW-bit pointers wrap modulo DEPTH for free.
  // NOTE: sequential state uses non-blocking assignment so every register in
  // the design samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-stage predictions in order and, when EXEC
// resolves the oldest instruction, checks the prediction against the outcome.
// Produces a one-cycle redirect on mispredict (which also flushes all younger
// wrong-path entries), a one-cycle predictor training pulse for every branch,
// and saturating branch / mispredict counters.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of branch_resolve_unit_if (CNT_W must match)
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  entry_t      head;
  entry_t      wr_data;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        flush;
  logic        actual_taken;
  logic        mispredict;
  logic [31:0] correct_pc;

  // Stall comes from the registered count only; a same-cycle pop does not
  // open a slot, so fetch simply retries next cycle.
  assign bus.f_stall = full;

  assign wr_data = '{pc: bus.f_pc, ptaken: bus.f_predict_valid,
                     ptarget: bus.f_predict_addr};

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    actual_taken = 1'b0;
    mispredict   = 1'b0;
    correct_pc   = '0;
    actual_taken = bus.x_is_branch && bus.x_taken;
    // A non-branch predicted taken is a mispredict with a fall-through fix-up.
    mispredict   = (head.ptaken != actual_taken) ||
                   (head.ptaken && actual_taken && (head.ptarget != bus.x_target));
    correct_pc   = actual_taken ? bus.x_target : head.pc + 32'(INSTR_BYTES);
  end

  assign pop   = bus.x_valid && !empty;
  assign flush = pop && mispredict;
  // A push racing a flush belongs to the wrong path and is dropped.
  assign push  = bus.f_valid && !full && !flush;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.redirect_valid   <= 1'b0;
      bus.redirect_pc      <= '0;
      bus.upd_valid        <= 1'b0;
      bus.upd_pc           <= '0;
      bus.upd_taken        <= 1'b0;
      bus.upd_target       <= '0;
      bus.stat_branches    <= '0;
      bus.stat_mispredicts <= '0;
      bus.underflow_err    <= 1'b0;
    end else begin
      // Pulses drop back to 0 by default; data outputs keep their last value.
      bus.redirect_valid <= flush;
      bus.upd_valid      <= pop && bus.x_is_branch;

      if (flush) bus.redirect_pc <= correct_pc;

      if (pop && bus.x_is_branch) begin
        bus.upd_pc     <= head.pc;
        bus.upd_taken  <= bus.x_taken;
        bus.upd_target <= bus.x_target;
        if (bus.stat_branches != '1)
          bus.stat_branches <= bus.stat_branches + CNT_W'(1);
      end

      if (flush && (bus.stat_mispredicts != '1))
        bus.stat_mispredicts <= bus.stat_mispredicts + CNT_W'(1);

      if (bus.x_valid && empty) bus.underflow_err <= 1'b1;
    end
  end

endmodule
